// File: rtl/qspi_rom_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : qspi_rom_reader_if                                     |
// | Description : Request/response and quad-SPI pin bundle for the       |
// |               qspi_rom_reader. The master modport is the reader.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface qspi_rom_reader_if #(
  parameter int ADDR_BITS = 24
);
  // Console-side request/response
  logic                 start;
  logic [ADDR_BITS-1:0] addr;
  logic                 busy;
  logic [7:0]           data;
  logic                 data_valid;

  // Flash-side pins; nibble bit3..0 maps to {uio5,uio4,uio2,uio1}
  logic                 spi_clk;
  logic                 spi_sel_n;
  logic [3:0]           spi_dout;
  logic [3:0]           spi_oe;
  logic [3:0]           spi_din;

  modport master (
    input  start, addr, spi_din,
    output busy, data, data_valid, spi_clk, spi_sel_n, spi_dout, spi_oe
  );

  modport slave (
    output start, addr, spi_din,
    input  busy, data, data_valid, spi_clk, spi_sel_n, spi_dout, spi_oe
  );
endinterface
`default_nettype wire

// File: rtl/qspi_rom_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : qspi_rom_reader                                        |
// | Description : Quad-SPI read initiator. Sends command, address and    |
// |               dummy cycles, then fetches one byte per request.       |
// |               Each SPI bit-cycle is two system clocks (L then H).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module qspi_rom_reader #(
  parameter int         ADDR_BITS    = 24,     // multiple of 4
  parameter logic [7:0] CMD          = 8'hEB,
  parameter int         DUMMY_CYCLES = 4       // at least 1
) (
  input  logic              clk,
  input  logic              reset,
  qspi_rom_reader_if.master bus
);

  localparam int ADDR_NIBBLES = ADDR_BITS / 4;
  localparam int SHIFT_BITS   = 8 + ADDR_BITS;
  // One down-counter serves every phase, so size it for the longest one.
  localparam int MAX_AD       = (ADDR_NIBBLES > DUMMY_CYCLES) ? ADDR_NIBBLES : DUMMY_CYCLES;
  localparam int MAX_NIB      = (MAX_AD > 2) ? MAX_AD : 2;
  localparam int CNT_W        = $clog2(MAX_NIB);

  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_DUMMY = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DATA  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_DESEL = 3'd5
  } state_t;

  state_t                r_state,   w_state;
  logic [CNT_W-1:0]      r_cnt,     w_cnt;
  logic                  r_phase,   w_phase;     // 0 = L phase, 1 = H phase
  logic                  r_spi_clk, w_spi_clk;
  logic                  r_sel_n,   w_sel_n;
  logic                  r_busy,    w_busy;
  logic [3:0]            r_oe,      w_oe;
  logic [SHIFT_BITS-1:0] r_shift,   w_shift;     // {CMD, addr}; top nibble is on the pins
  logic [3:0]            r_rx,      w_rx;        // high data nibble waiting for the low one
  logic [7:0]            r_data,    w_data;
  logic                  r_valid,   w_valid;

  // State and every pin-facing output are registered so spi_clk and sel_n cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_spi_clk <= 1'b0;
      r_sel_n   <= 1'b1;
      r_busy    <= 1'b0;
      r_oe      <= 4'hF;
      r_shift   <= '0;
      r_rx      <= 4'h0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_phase   <= w_phase;
      r_spi_clk <= w_spi_clk;
      r_sel_n   <= w_sel_n;
      r_busy    <= w_busy;
      r_oe      <= w_oe;
      r_shift   <= w_shift;
      r_rx      <= w_rx;
      r_data    <= w_data;
      r_valid   <= w_valid;
    end
  end

  // Next-state and next-output logic. Phase changes happen on the edge that
  // ends an H phase, which is also where the flash nibble is sampled.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_phase   = r_phase;
    w_spi_clk = r_spi_clk;
    w_sel_n   = r_sel_n;
    w_busy    = r_busy;
    w_oe      = r_oe;
    w_shift   = r_shift;
    w_rx      = r_rx;
    w_data    = r_data;
    w_valid   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sel_n   = 1'b1;
        w_spi_clk = 1'b0;
        if (bus.start) begin
          w_state = S_CMD;
          w_cnt   = CNT_CMD;
          w_phase = 1'b0;
          w_sel_n = 1'b0;
          w_busy  = 1'b1;
          w_oe    = 4'hF;
          w_shift = {CMD, bus.addr};
        end else begin
          w_busy  = 1'b0;
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!r_phase) begin
          w_phase   = 1'b1;
          w_spi_clk = 1'b1;
        end else begin
          w_phase   = 1'b0;
          w_spi_clk = 1'b0;
          // Zeros shift in behind the address, so dummy cycles send 0.
          w_shift   = r_shift << 4;
          w_cnt     = r_cnt - 1'b1;
          if (r_state == S_DATA) begin
            w_rx = bus.spi_din;
          end
          if (r_cnt == '0) begin
            case (r_state)
              S_CMD: begin
                w_state = S_ADDR;
                w_cnt   = CNT_ADDR;
              end
              S_ADDR: begin
                w_state = S_DUMMY;
                w_cnt   = CNT_DUMMY;
                w_oe    = 4'h0;     // release the bus before the flash turns it around
              end
              S_DUMMY: begin
                w_state = S_DATA;
                w_cnt   = CNT_DATA;
              end
              default: begin      // S_DATA: low nibble arrives now
                w_state = S_DESEL;
                w_oe    = 4'hF;
                w_data  = {r_rx, bus.spi_din};
                w_valid = 1'b1;
              end
            endcase
          end
        end
      end

      // Registered outputs lag the state by one clock here: sel_n rises as
      // the FSM re-enters IDLE, so the deselected cycle still shows busy=1.
      S_DESEL: begin
        w_state   = S_IDLE;
        w_sel_n   = 1'b1;
        w_spi_clk = 1'b0;
      end

      default: begin
        w_state   = S_IDLE;
        w_sel_n   = 1'b1;
        w_spi_clk = 1'b0;
        w_busy    = 1'b0;
        w_oe      = 4'hF;
      end
    endcase
  end

  assign bus.spi_clk    = r_spi_clk;
  assign bus.spi_sel_n  = r_sel_n;
  assign bus.spi_dout   = r_shift[SHIFT_BITS-1 -: 4];
  assign bus.spi_oe     = r_oe;
  assign bus.busy       = r_busy;
  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;

endmodule
`default_nettype wire
